bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 m0_addr, m1_addr  input  30  word address from master 0 (CPU core) / master 1 (secondary master).
REQ-005 m0_data_wr, m1_data_wr  input  32  write data per master.
REQ-006 m0_write, m1_write  input  1  1 = write, 0 = read.
REQ-007 m0_start, m1_start  input  1  one-cycle request pulse; addr/data_wr/write valid in same cycle.
REQ-008 m0_ready, m1_ready  output  1  one-cycle completion pulse to owning master.
REQ-009 m0_data_rd, m1_data_rd  output  32  read data, valid only while matching ready=1, else 0.
REQ-010 s_addr  output  30, s_data_wr  output  32, s_write  output  1  request fields to the shared bus.
REQ-011 s_start  output  1  one-cycle request pulse to the shared bus.
REQ-012 s_data_rd  input  32, s_ready  input  1  shared-bus response.

Function
REQ-013 Per master N: a pending flag pendN plus latched addr/data_wr/write; mN_start=1 with pendN=0 SHALL set pendN and capture fields at that edge.
REQ-014 mN_start=1 while pendN=1 and no completion that cycle SHALL be ignored (latched fields unchanged).
REQ-015 FSM states IDLE, BUSY0, BUSY1; reset state IDLE.
REQ-016 IDLE: pend0 only -> BUSY0; pend1 only -> BUSY1; both -> master != last_grant; neither -> stay IDLE.
REQ-017 last_grant SHALL reset to 1 so master 0 wins the first tie; updates to N on completion of BUSYN.
REQ-018 s_start SHALL be 1 exactly in the first cycle of each BUSYN visit, 0 otherwise.
REQ-019 In BUSYN, s_addr/s_data_wr/s_write SHALL equal master N's latched fields; in IDLE all three SHALL be 0.
REQ-020 Latency: mN_start at edge t with FSM IDLE and no contention -> BUSYN from edge t+1 -> s_start high in cycle t+1..t+2 (two edges after request).
REQ-021 In BUSYN, s_ready=1 (including the s_start cycle, zero-wait slave) SHALL combinationally drive mN_ready=1 and mN_data_rd=s_data_rd; the other master's ready/data_rd stay 0.
REQ-022 On that edge: pendN cleared, last_grant=N, FSM -> IDLE; minimum one IDLE cycle between transactions.
REQ-023 mN_start in the same cycle as own completion SHALL take priority: pendN stays 1 with new fields captured.
REQ-024 s_ready in IDLE SHALL be ignored: no mN_ready, no state change.
REQ-025 A request from the non-owning master during BUSY SHALL be latched and served next, never dropped.
REQ-026 No timeout; BUSYN holds indefinitely until s_ready.

Reset
REQ-027 rst_n=0 at an edge SHALL clear pend0, pend1, latched fields to 0, FSM=IDLE, last_grant=1.
REQ-028 During and after reset: s_start=0, s_addr=0, s_data_wr=0, s_write=0; m0_ready=m1_ready=0 (s_ready ignored in IDLE).
REQ-029 Reset mid-transaction SHALL abandon it: no ready to either master; a late s_ready after reset is discarded per REQ-024.

Verification
REQ-030 Single read: m0_start, m0_addr=0x0000100, write=0 -> s_start 2 edges later with s_addr=0x0000100; slave s_ready with s_data_rd=0xDEADBEEF 3 cycles later -> m0_ready=1, m0_data_rd=0xDEADBEEF same cycle, m1_ready=0.
REQ-031 Tie: m0_start and m1_start same cycle after reset -> master 0 served first, then master 1; repeat tie -> master 0 again (last_grant=1).
REQ-032 Fairness: both masters re-issue start immediately on their ready, 10 transactions each -> grants strictly alternate 0,1,0,1.
REQ-033 Write forwarding: m1_start, m1_write=1, m1_addr=0x3FFFFFFF, m1_data_wr=0x12345678 -> s_write=1, s_addr=0x3FFFFFFF, s_data_wr=0x12345678 stable from s_start until s_ready.
REQ-034 Zero-wait slave: s_ready asserted in s_start cycle -> ready to owner that cycle; FSM IDLE next cycle.
REQ-035 Reset in BUSY0 before s_ready, then s_ready=1 one cycle after reset release -> no m0_ready/m1_ready, FSM IDLE, pend0=0.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master to one-slave bus arbiter. Each master's request
//               is latched into a pending slot. An FSM grants the shared bus
//               to one master at a time, and the last-granted master loses
//               ties. The slave response is forwarded combinationally to the
//               owning master.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_data_wr,
    input  logic        m0_write,
    input  logic        m0_start,
    output logic        m0_ready,
    output logic [31:0] m0_data_rd,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_data_wr,
    input  logic        m1_write,
    input  logic        m1_start,
    output logic        m1_ready,
    output logic [31:0] m1_data_rd,
    output logic [29:0] s_addr,
    output logic [31:0] s_data_wr,
    output logic        s_write,
    output logic        s_start,
    input  logic [31:0] s_data_rd,
    input  logic        s_ready
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY0 = 2'd1;
    localparam logic [1:0] c_BUSY1 = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_first;
    logic        r_last_grant;

    logic        r_pend0;
    logic [29:0] r_addr0;
    logic [31:0] r_data0;
    logic        r_write0;
    logic        r_pend1;
    logic [29:0] r_addr1;
    logic [31:0] r_data1;
    logic        r_write1;

    logic        w_done0;
    logic        w_done1;

    // A transaction completes when the slave answers while that master owns the bus
    assign w_done0 = (r_state == c_BUSY0) && s_ready;
    assign w_done1 = (r_state == c_BUSY1) && s_ready;

    // State register, first-cycle marker for s_start, and tie-break history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_first      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_first <= (r_state == c_IDLE) && (w_state_next != c_IDLE);
            if (w_done0) begin
                r_last_grant <= 1'b0;
            end else if (w_done1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // Next-state logic: grant from IDLE, return to IDLE on slave response
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_pend0 && r_pend1) begin
                    w_state_next = r_last_grant ? c_BUSY0 : c_BUSY1;
                end else if (r_pend0) begin
                    w_state_next = c_BUSY0;
                end else if (r_pend1) begin
                    w_state_next = c_BUSY1;
                end
            end
            c_BUSY0: if (s_ready) w_state_next = c_IDLE;
            c_BUSY1: if (s_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Master 0 pending slot; a new start at completion re-arms it with new fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend0  <= 1'b0;
            r_addr0  <= 30'd0;
            r_data0  <= 32'd0;
            r_write0 <= 1'b0;
        end else if (m0_start && (!r_pend0 || w_done0)) begin
            r_pend0  <= 1'b1;
            r_addr0  <= m0_addr;
            r_data0  <= m0_data_wr;
            r_write0 <= m0_write;
        end else if (w_done0) begin
            r_pend0  <= 1'b0;
        end
    end

    // Master 1 pending slot; same capture rules as master 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend1  <= 1'b0;
            r_addr1  <= 30'd0;
            r_data1  <= 32'd0;
            r_write1 <= 1'b0;
        end else if (m1_start && (!r_pend1 || w_done1)) begin
            r_pend1  <= 1'b1;
            r_addr1  <= m1_addr;
            r_data1  <= m1_data_wr;
            r_write1 <= m1_write;
        end else if (w_done1) begin
            r_pend1  <= 1'b0;
        end
    end

    // Output logic: drive owner's fields to the slave, route response to owner
    always_comb begin
        s_start    = r_first && (r_state != c_IDLE);
        s_addr     = 30'd0;
        s_data_wr  = 32'd0;
        s_write    = 1'b0;
        m0_ready   = w_done0;
        m1_ready   = w_done1;
        m0_data_rd = w_done0 ? s_data_rd : 32'd0;
        m1_data_rd = w_done1 ? s_data_rd : 32'd0;
        if (r_state == c_BUSY0) begin
            s_addr    = r_addr0;
            s_data_wr = r_data0;
            s_write   = r_write0;
        end else if (r_state == c_BUSY1) begin
            s_addr    = r_addr1;
            s_data_wr = r_data1;
            s_write   = r_write1;
        end
    end

endmodule
`default_nettype wire
